// File: rtl/morse_sequencer_if.sv
// Handshake and shift-register control bundle for the morse sequencer.
// The slave side is the sequencer; the master side is the surrounding logic plus the register.
interface morse_sequencer_if;
    logic        start;
    logic [2:0]  letter;
    logic [15:0] sr_q;
    logic [15:0] sr_data;
    logic        sr_load_n;
    logic        sr_rotate_right;
    logic        sr_ls_right;
    logic        busy;
    logic        done;
    logic        morse_out;

    modport master (
        output start, letter, sr_q,
        input  sr_data, sr_load_n, sr_rotate_right, sr_ls_right, busy, done, morse_out
    );

    modport slave (
        input  start, letter, sr_q,
        output sr_data, sr_load_n, sr_rotate_right, sr_ls_right, busy, done, morse_out
    );
endinterface

// File: rtl/morse_sequencer.sv
// Loads a letter pattern into an external 16-bit shift register and shifts it out
// LSB-first, one bit per morse unit, with a start/busy/done handshake.
module morse_sequencer #(
    parameter int TICKS_PER_UNIT = 25000000,
    parameter int CNT_W          = 26
) (
    input  logic              clock,
    input  logic              reset,
    morse_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(TICKS_PER_UNIT - 1);

    state_t           state_q, state_d;
    logic [2:0]       letter_q, letter_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [15:0] sr_data;
    logic        sr_load_n;
    logic        sr_rotate_right;
    logic        sr_ls_right;
    logic        busy;
    logic        done;
    logic        morse_out;

    // Each pattern ends on its highest set bit, which is how SEND detects the last element.
    function automatic logic [15:0] pattern(input logic [2:0] sel);
        logic [15:0] p;
        case (sel)
            3'd0:    p = 16'h0015;
            3'd1:    p = 16'h0007;
            3'd2:    p = 16'h0075;
            3'd3:    p = 16'h01D5;
            3'd4:    p = 16'h01DD;
            3'd5:    p = 16'h0757;
            3'd6:    p = 16'h1DD7;
            default: p = 16'h0577;
        endcase
        return p;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            letter_q <= 3'd0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            letter_q <= letter_d;
            cnt_q    <= cnt_d;
        end
    end

    // The register has no hold mode, so every state drives a load or a shift each cycle.
    always_comb begin
        state_d         = state_q;
        letter_d        = letter_q;
        cnt_d           = cnt_q;
        sr_data         = 16'h0000;
        sr_load_n       = 1'b0;
        sr_rotate_right = 1'b0;
        sr_ls_right     = 1'b0;
        busy            = 1'b0;
        done            = 1'b0;
        morse_out       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    letter_d = bus.letter;
                    state_d  = ST_LOAD;
                end
            end

            ST_LOAD: begin
                busy    = 1'b1;
                sr_data = pattern(letter_q);
                cnt_d   = '0;
                state_d = ST_SEND;
            end

            ST_SEND: begin
                busy      = 1'b1;
                morse_out = bus.sr_q[0];
                if (cnt_q == LAST_TICK) begin
                    sr_load_n       = 1'b1;
                    sr_rotate_right = 1'b1;
                    sr_ls_right     = 1'b1;
                    cnt_d           = '0;
                    if (bus.sr_q[15:1] == 15'd0)
                        state_d = ST_DONE;
                end else begin
                    sr_data = bus.sr_q;
                    cnt_d   = cnt_q + 1'b1;
                end
            end

            default: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.sr_data         = sr_data;
    assign bus.sr_load_n       = sr_load_n;
    assign bus.sr_rotate_right = sr_rotate_right;
    assign bus.sr_ls_right     = sr_ls_right;
    assign bus.busy            = busy;
    assign bus.done            = done;
    assign bus.morse_out       = morse_out;

endmodule
